// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: circular sample buffer that cuts a free-running stream into
// overlapping Avalon-ST frames for the streaming FFT sink.
module fft_frame_feeder #(
  parameter int DATA_W = 16,
  parameter int PTS_W  = 12,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_real,
  input  logic [PTS_W-1:0]  cfg_fftpts,
  input  logic [PTS_W-1:0]  cfg_hop,
  input  logic              cfg_inverse,
  input  logic              ovf_clr,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [DATA_W-1:0] src_real,
  output logic [DATA_W-1:0] src_imag,
  output logic [1:0]        src_error,
  output logic [PTS_W-1:0]  src_fftpts,
  output logic              src_inverse,
  output logic              overflow,
  output logic [ADDR_W:0]   fill
);
  localparam int D = 1 << ADDR_W;
  localparam logic [PTS_W-1:0] D_PTS = PTS_W'(D);
  localparam logic [ADDR_W:0] D_FILL = (ADDR_W+1)'(D);
  typedef enum logic [1:0] {IDLE, STREAM, RELEASE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [D];
  logic [DATA_W-1:0] rd_data, e1_real;
  logic [ADDR_W-1:0] wr_ptr, base, rd_addr;
  logic [PTS_W-1:0] n_c, h_c, h_r, idx;
  logic [1:0] cnt, cnt_n;
  logic [2:0] occ;
  logic we, start, issue, pop, inflight, rd_sop, rd_eop, e1_sop, e1_eop;
  assign src_imag = '0;
  assign src_error = '0;
  assign we = in_valid && fill != D_FILL;
  assign n_c = (cfg_fftpts == '0 || cfg_fftpts > D_PTS) ? D_PTS : cfg_fftpts;
  assign h_c = (cfg_hop == '0 || cfg_hop > n_c) ? n_c : cfg_hop;
  assign start = state == IDLE && PTS_W'(fill) >= n_c;
  assign pop = src_valid && src_ready;
  // the first read is issued in the start cycle itself so sop appears two cycles after the decision
  assign rd_addr = start ? base : base + idx[ADDR_W-1:0];
  assign occ = 3'(cnt) + 3'(inflight);
  assign issue = start || (state == STREAM && idx < src_fftpts && occ < 3'd2 + 3'(pop));
  assign cnt_n = cnt + 2'(inflight) - 2'(pop);
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= in_real;
    if (issue) rd_data <= mem[rd_addr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      base <= '0;
      fill <= '0;
      overflow <= 1'b0;
      idx <= '0;
      h_r <= '0;
      inflight <= 1'b0;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
      cnt <= '0;
      src_valid <= 1'b0;
      src_sop <= 1'b0;
      src_eop <= 1'b0;
      src_real <= '0;
      src_fftpts <= '0;
      src_inverse <= 1'b0;
      e1_real <= '0;
      e1_sop <= 1'b0;
      e1_eop <= 1'b0;
    end else begin
      fill <= fill + (ADDR_W+1)'(we) - (state == RELEASE ? (ADDR_W+1)'(h_r) : '0);
      if (we) wr_ptr <= wr_ptr + ADDR_W'(1);
      overflow <= (in_valid && !we) || (overflow && !ovf_clr);
      inflight <= issue;
      if (issue) begin
        rd_sop <= start;
        rd_eop <= start ? n_c == PTS_W'(1) : idx == src_fftpts - PTS_W'(1);
      end
      if (start) idx <= PTS_W'(1);
      else if (issue) idx <= idx + PTS_W'(1);
      if (state == IDLE) begin
        if (start) begin
          state <= STREAM;
          h_r <= h_c;
          src_fftpts <= n_c;
          src_inverse <= cfg_inverse;
        end
      end else if (state == STREAM) begin
        if (pop && src_eop) state <= RELEASE;
      end else begin
        base <= base + ADDR_W'(h_r);
        state <= IDLE;
      end
      // two-entry skid: the head drives src_*, the second entry absorbs the in-flight read
      cnt <= cnt_n;
      src_valid <= cnt_n != 2'd0;
      if (inflight && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
        {src_real, src_sop, src_eop} <= {rd_data, rd_sop, rd_eop};
      else if (pop && cnt == 2'd2)
        {src_real, src_sop, src_eop} <= {e1_real, e1_sop, e1_eop};
      if (inflight && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop)))
        {e1_real, e1_sop, e1_eop} <= {rd_data, rd_sop, rd_eop};
    end
  end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed table-driven bench for the frame feeder with
// D=16, plus hand sequences for overflow and mid-frame reset.
module tb_fft_frame_feeder;
  localparam int DW = 16, PW = 12, AW = 4;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, cfg_inverse = 1'b0;
  logic ovf_clr = 1'b0, src_ready = 1'b0;
  logic [DW-1:0] in_real = '0;
  logic [PW-1:0] cfg_fftpts = '0, cfg_hop = '0;
  logic src_valid, src_sop, src_eop, src_inverse, overflow;
  logic [DW-1:0] src_real, src_imag;
  logic [1:0] src_error;
  logic [PW-1:0] src_fftpts;
  logic [AW:0] fill;
  always #5 clk = ~clk;
  fft_frame_feeder #(.DATA_W(DW), .PTS_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_real(in_real),
    .cfg_fftpts(cfg_fftpts), .cfg_hop(cfg_hop), .cfg_inverse(cfg_inverse),
    .ovf_clr(ovf_clr), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop), .src_real(src_real),
    .src_imag(src_imag), .src_error(src_error), .src_fftpts(src_fftpts),
    .src_inverse(src_inverse), .overflow(overflow), .fill(fill)
  );
  typedef struct packed {
    int n, h, n_in, rate;
    bit rnd, inv;
    int frames, len, fpts, s0, s1, s2, fill;
  } vec_t;
  vec_t vecs [5];
  int checks = 0, errors = 0, cyc = 0;
  int q_val[$], q_sop[$], q_eop[$], q_pts[$], q_inv[$], q_cyc[$];
  bit stall_prev = 1'b0;
  logic [DW+1:0] p_beat = '0;
  logic [15:0] pat = 16'b1001_1011_0100_1101;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic sample();
    if (stall_prev) begin
      chk("stall_valid", int'(src_valid), 1);
      chk("stall_beat", int'({src_sop, src_eop, src_real}), int'(p_beat));
    end
    if (src_valid && src_ready) begin
      q_val.push_back(int'(src_real));
      q_sop.push_back(int'(src_sop));
      q_eop.push_back(int'(src_eop));
      q_pts.push_back(int'(src_fftpts));
      q_inv.push_back(int'(src_inverse));
      q_cyc.push_back(cyc);
    end
    stall_prev = src_valid && !src_ready && reset_n;
    p_beat = {src_sop, src_eop, src_real};
  endtask
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic clear_q();
    q_val.delete(); q_sop.delete(); q_eop.delete();
    q_pts.delete(); q_inv.delete(); q_cyc.delete();
    stall_prev = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    clear_q();
    step();
  endtask
  task automatic feed(input int n, input int rate, input int first, input bit rnd, input int extra);
    for (int c = 0; c < n * rate + extra; c++) begin
      in_valid = c < n * rate && c % rate == 0;
      in_real = DW'(first + c / rate);
      if (rnd) src_ready = pat[c % 16];
      step();
    end
    in_valid = 1'b0;
  endtask
  initial begin
    vec_t v;
    int f, k, s;
    vecs[0] = '{8, 8, 8, 1, 1'b0, 1'b0, 1, 8, 8, 1, 0, 0, 0};
    vecs[1] = '{8, 4, 16, 1, 1'b0, 1'b1, 3, 8, 8, 1, 5, 9, 4};
    vecs[2] = '{0, 0, 16, 1, 1'b0, 1'b0, 1, 16, 16, 1, 0, 0, 0};
    vecs[3] = '{8, 20, 16, 1, 1'b1, 1'b0, 2, 8, 8, 1, 9, 0, 0};
    vecs[4] = '{8, 6, 20, 2, 1'b0, 1'b0, 3, 8, 8, 1, 7, 13, 2};
    step();
    chk("rst_valid", int'(src_valid), 0);
    chk("rst_sop_eop", int'({src_sop, src_eop}), 0);
    chk("rst_real", int'(src_real), 0);
    chk("rst_fftpts", int'(src_fftpts), 0);
    chk("rst_inverse", int'(src_inverse), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_imag_err", int'({src_imag, src_error}), 0);
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      do_reset();
      cfg_fftpts = PW'(v.n);
      cfg_hop = PW'(v.h);
      cfg_inverse = v.inv;
      src_ready = 1'b1;
      feed(v.n_in, v.rate, 1, v.rnd, 150);
      src_ready = 1'b1;
      chk($sformatf("c%0d_beats", i), q_val.size(), v.frames * v.len);
      for (int b = 0; b < q_val.size() && b < v.frames * v.len; b++) begin
        f = b / v.len;
        k = b % v.len;
        s = f == 0 ? v.s0 : f == 1 ? v.s1 : v.s2;
        chk($sformatf("c%0d_val%0d", i, b), q_val[b], s + k);
        chk($sformatf("c%0d_sop%0d", i, b), q_sop[b], int'(k == 0));
        chk($sformatf("c%0d_eop%0d", i, b), q_eop[b], int'(k == v.len - 1));
        chk($sformatf("c%0d_pts%0d", i, b), q_pts[b], v.fpts);
        chk($sformatf("c%0d_inv%0d", i, b), q_inv[b], int'(v.inv));
        if (!v.rnd && k > 0) chk($sformatf("c%0d_gap%0d", i, b), q_cyc[b] - q_cyc[b-1], 1);
      end
      chk($sformatf("c%0d_fill", i), int'(fill), v.fill);
      chk($sformatf("c%0d_ovf", i), int'(overflow), 0);
    end
    do_reset();
    cfg_fftpts = 12'd8;
    cfg_hop = 12'd8;
    cfg_inverse = 1'b0;
    src_ready = 1'b0;
    feed(20, 1, 1, 1'b0, 0);
    step();
    chk("ovf_fill_full", int'(fill), 16);
    chk("ovf_set", int'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clear1", int'(overflow), 0);
    in_valid = 1'b1;
    in_real = DW'(99);
    ovf_clr = 1'b1;
    step();
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clear2", int'(overflow), 0);
    chk("ovf_fill_hold", int'(fill), 16);
    src_ready = 1'b1;
    feed(0, 1, 0, 1'b0, 60);
    chk("ovf_beats", q_val.size(), 16);
    for (int b = 0; b < q_val.size() && b < 16; b++)
      chk($sformatf("ovf_val%0d", b), q_val[b], b + 1);
    chk("ovf_fill_end", int'(fill), 0);
    do_reset();
    feed(8, 1, 1, 1'b0, 0);
    for (int w = 0; w < 40 && q_val.size() < 3; w++) step();
    chk("mid_wait", int'(q_val.size() >= 3), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_valid", int'(src_valid), 0);
    chk("mid_sop", int'(src_sop), 0);
    chk("mid_real", int'(src_real), 0);
    chk("mid_fill", int'(fill), 0);
    chk("mid_fftpts", int'(src_fftpts), 0);
    clear_q();
    step();
    reset_n = 1'b1;
    feed(7, 1, 101, 1'b0, 20);
    chk("mid_no_frame", q_val.size(), 0);
    chk("mid_fill7", int'(fill), 7);
    feed(1, 1, 108, 1'b0, 30);
    chk("mid_beats", q_val.size(), 8);
    for (int b = 0; b < q_val.size() && b < 8; b++) begin
      chk($sformatf("mid_val%0d", b), q_val[b], 101 + b);
      chk($sformatf("mid_sop%0d", b), q_sop[b], int'(b == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
